// File: rtl/instruction_fetch.sv
`default_nettype none
//============================================================================
// Module   : instruction_fetch
// Purpose  : Fetches instruction words from instruction memory. It
//            requests pc, waits for the acknowledge and presents the word
//            to decode until decode accepts it. Decode then supplies the
//            next-PC selection.
//            If memory never acknowledges a request, the module enters a
//            sticky fault state that only reset clears.
// Ports    : clk, rst_n               clock, async active-low reset
//            imem_req/addr/rdata/ack  instruction-memory read port
//            inst, inst_valid, inst_ready  handshake to decode
//            pc                       address of current instruction
//            pc_src, jump_addr, imm, br_taken  next-PC controls (HOLD only)
//            fault                    sticky memory-timeout flag
// Revision : 1.0  initial release
//============================================================================

`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_PC_SRC
`define W_PC_SRC 2
`endif
`ifndef W_JADDR
`define W_JADDR 26
`endif
`ifndef W_IMM
`define W_IMM 16
`endif

module instruction_fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0040_0000,
    parameter int          TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [`W_CPU-1:0]     imem_addr,
    input  logic [`W_CPU-1:0]     imem_rdata,
    input  logic                  imem_ack,
    output logic [`W_CPU-1:0]     inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [`W_CPU-1:0]     pc,
    input  logic [`W_PC_SRC-1:0]  pc_src,
    input  logic [`W_JADDR-1:0]   jump_addr,
    input  logic [`W_IMM-1:0]     imm,
    input  logic                  br_taken,
    output logic                  fault
);

    localparam logic [`W_PC_SRC-1:0] c_PC_SRC_NEXT = `W_PC_SRC'd0;
    localparam logic [`W_PC_SRC-1:0] c_PC_SRC_BRCH = `W_PC_SRC'd1;
    localparam logic [`W_PC_SRC-1:0] c_PC_SRC_JUMP = `W_PC_SRC'd2;
    localparam logic [7:0]           c_TIMEOUT     = 8'(TIMEOUT);
    localparam logic [`W_CPU-1:0]    c_RESET_PC    = {RESET_VEC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_run;        // low for the first cycle after reset release
    logic [7:0]         r_wait_cnt;
    logic [7:0]         w_cnt_inc;
    logic [`W_CPU-1:0]  r_pc;
    logic [`W_CPU-1:0]  r_inst;
    logic               r_inst_valid;
    logic               r_fault;
    logic               w_capture;
    logic               w_accept;
    logic [`W_CPU-1:0]  w_pc_plus4;
    logic [`W_CPU-1:0]  w_br_off;
    logic [`W_CPU-1:0]  w_next_pc;

    assign w_cnt_inc  = r_wait_cnt + 8'd1;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pc_src)
            c_PC_SRC_NEXT: w_next_pc = w_pc_plus4;
            c_PC_SRC_BRCH: w_next_pc = br_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
            c_PC_SRC_JUMP: w_next_pc = {w_pc_plus4[31:28], jump_addr, 2'b00};
            default:       w_next_pc = w_pc_plus4;
        endcase
    end

    // Next-state logic. An acknowledge arriving on the same cycle the
    // wait counter would expire takes priority over the timeout.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_REQ: begin
                if (r_run) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    w_state_next = S_HOLD;
                    w_capture    = 1'b1;
                end else if (w_cnt_inc == c_TIMEOUT) begin
                    w_state_next = S_FAULT;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    w_state_next = S_REQ;
                    w_accept     = 1'b1;
                end
            end
            S_FAULT: w_state_next = S_FAULT;
            default: w_state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run        <= 1'b0;
            r_wait_cnt   <= 8'd0;
            r_pc         <= c_RESET_PC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_run <= 1'b1;

            if (r_state == S_WAIT && !imem_ack) begin
                r_wait_cnt <= w_cnt_inc;
            end else if (r_state == S_REQ || w_accept) begin
                r_wait_cnt <= 8'd0;
            end

            if (w_capture) begin
                r_inst       <= imem_rdata;
                r_inst_valid <= 1'b1;
            end

            if (w_accept) begin
                r_pc         <= {w_next_pc[31:2], 2'b00};
                r_inst_valid <= 1'b0;
            end

            if (w_state_next == S_FAULT) begin
                r_fault      <= 1'b1;
                r_inst_valid <= 1'b0;
            end
        end
    end

    // r_run keeps the request low until the first edge after reset release.
    assign imem_req   = r_run && (r_state == S_REQ || r_state == S_WAIT);
    assign imem_addr  = {r_pc[31:2], 2'b00};
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign fault      = r_fault;

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VEC, default 32'h0040_0000, PC loaded at reset.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles spent in WAIT before FAULT (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  `W_CPU  word address of request (equals pc).
REQ-007 imem_rdata  input  `W_CPU  instruction word returned by memory.
REQ-008 imem_ack  input  1  imem_rdata valid this cycle.
REQ-009 inst  output  `W_CPU  registered instruction presented to decode.
REQ-010 inst_valid  output  1  inst holds a fetched, unconsumed instruction.
REQ-011 inst_ready  input  1  downstream accepts inst this cycle.
REQ-012 pc  output  `W_CPU  address of the instruction in inst / being fetched.
REQ-013 pc_src  input  `W_PC_SRC  next-PC select from decode (PC_SRC_NEXT / PC_SRC_BRCH / PC_SRC_JUMP).
REQ-014 jump_addr  input  `W_JADDR  jump target field from decode.
REQ-015 imm  input  `W_IMM  branch offset field from decode.
REQ-016 br_taken  input  1  branch condition resolved by execute; meaningful only with PC_SRC_BRCH.
REQ-017 fault  output  1  sticky memory-timeout indication.

Function
REQ-018 FSM states SHALL be REQ, WAIT, HOLD, FAULT; only REQ and WAIT request memory.
REQ-019 REQ: imem_req=1, imem_addr=pc; next state WAIT unconditionally.
REQ-020 WAIT: imem_req=1, imem_addr=pc; on imem_ack=1 capture imem_rdata into inst, set inst_valid=1, go HOLD (inst_valid visible the cycle after ack).
REQ-021 WAIT: 8-bit wait counter increments each cycle without ack; when counter reaches TIMEOUT without ack, go FAULT.
REQ-022 Wait counter SHALL clear on entry to REQ.
REQ-023 HOLD: imem_req=0; inst and pc held stable while inst_ready=0.
REQ-024 HOLD with inst_ready=1: pc <= next_pc, inst_valid <= 0, go REQ; handshake completes in exactly one edge.
REQ-025 pc_plus4 = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-026 next_pc for PC_SRC_NEXT = pc_plus4.
REQ-027 next_pc for PC_SRC_BRCH and br_taken=1 = pc_plus4 + (sign-extended imm << 2), modulo 2^32; with br_taken=0 = pc_plus4.
REQ-028 next_pc for PC_SRC_JUMP = {pc_plus4[31:28], jump_addr, 2'b00}.
REQ-029 Any other pc_src encoding SHALL yield pc_plus4.
REQ-030 pc_src, jump_addr, imm, br_taken sampled only on the HOLD-accept edge; ignored otherwise.
REQ-031 imem_ack outside WAIT SHALL be ignored (no capture, no state change).
REQ-032 imem_ack in the same cycle WAIT counter reaches TIMEOUT: ack wins, go HOLD.
REQ-033 FAULT: imem_req=0, inst_valid=0, fault=1; state held until reset.
REQ-034 imem_addr[1:0] SHALL always be 2'b00.
REQ-035 Fetch throughput: minimum 3 cycles per instruction (REQ, WAIT-ack, HOLD-accept).

Reset
REQ-036 rst_n=0 SHALL immediately force: state REQ, pc=RESET_VEC, inst=0, inst_valid=0, fault=0, wait counter=0, imem_req=0 while rst_n=0.
REQ-037 Reset asserted mid-WAIT or mid-HOLD SHALL discard the pending fetch/instruction; first request after release uses RESET_VEC.
REQ-038 imem_req SHALL rise on the first rising edge after rst_n deasserts (REQ state drives it).

Verification
REQ-039 Reset release, imem_ack on 1st WAIT cycle with rdata=32'h2008_0005, inst_ready=1 -> imem_addr=0x0040_0000, inst=32'h2008_0005, next fetch address 0x0040_0004.
REQ-040 pc=0x0040_0010, HOLD, pc_src=PC_SRC_BRCH, imm=16'hFFFE, br_taken=1 -> next imem_addr=0x0040_000C; same with br_taken=0 -> 0x0040_0014.
REQ-041 pc=0x0040_0020, pc_src=PC_SRC_JUMP, jump_addr=26'h010_0008 -> next imem_addr=0x0040_0020.
REQ-042 inst_ready held 0 for 5 cycles in HOLD, then 1 -> inst, pc, inst_valid stable for all 5 cycles; pc advances only on accept edge; no imem_req during HOLD.
REQ-043 No imem_ack for TIMEOUT cycles -> fault=1, imem_req=0, inst_valid=0; later ack ignored; rst_n pulse clears fault and restarts at RESET_VEC.
REQ-044 pc=0xFFFF_FFFC, PC_SRC_NEXT accept -> next imem_addr=0x0000_0000.
